// File: rtl/path_metric_select.sv
// Min/max path-metric search: captures NUM_PATH metrics on start, scans LANES per cycle.
// Latency NUM_PATH/LANES+1 cycles to a one-cycle done pulse; start is ignored while busy, flush aborts.
module path_metric_select #(
  parameter int NUM_PATH = 16,
  parameter int MW       = 30,
  parameter int LANES    = 1,
  localparam int IDXW    = $clog2(NUM_PATH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   flush,
  input  logic                   sel_max,
  input  logic [NUM_PATH*MW-1:0] metric_in,
  output logic                   busy,
  output logic                   done,
  output logic [IDXW-1:0]        best_idx,
  output logic [MW-1:0]          best_metric
);

  localparam int G        = NUM_PATH / LANES;
  localparam int GW       = (G > 1) ? $clog2(G) : 1;
  localparam int LAST_GRP = G - 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic [MW-1:0]   bank [NUM_PATH];
  logic            bank_max;
  logic [MW-1:0]   run_best;
  logic [IDXW-1:0] run_idx;
  logic [GW-1:0]   grp;
  logic [MW-1:0]   chain_best;
  logic [IDXW-1:0] chain_idx;
  logic [IDXW-1:0] base;
  logic [IDXW-1:0] cand_idx;
  logic [MW-1:0]   cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start && !flush) begin
        state_nxt = SCAN;
        accept    = 1'b1;
      end
      SCAN: begin
        if (flush)                        state_nxt = IDLE;
        else if (grp == GW'(LAST_GRP))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // In-order chain across the lanes of one group; strict compare keeps the lowest index on ties.
  always_comb begin
    chain_best = run_best;
    chain_idx  = run_idx;
    base       = IDXW'(grp) * IDXW'(LANES);
    cand_idx   = base;
    cand       = '0;
    for (int l = 0; l < LANES; l++) begin
      cand_idx = base + IDXW'(l);
      cand     = bank[cand_idx];
      if (bank_max ? (cand > chain_best) : (cand < chain_best)) begin
        chain_best = cand;
        chain_idx  = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PATH; p++) bank[p] <= '0;
      bank_max    <= 1'b0;
      run_best    <= '0;
      run_idx     <= '0;
      grp         <= '0;
      best_idx    <= '0;
      best_metric <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        for (int p = 0; p < NUM_PATH; p++) bank[p] <= metric_in[p*MW +: MW];
        bank_max <= sel_max;
        run_best <= metric_in[0 +: MW];
        run_idx  <= '0;
        grp      <= '0;
      end else if (state == SCAN && !flush) begin
        run_best <= chain_best;
        run_idx  <= chain_idx;
        grp      <= grp + GW'(1);
      end
      if (state == DONE) begin
        best_idx    <= run_idx;
        best_metric <= run_best;
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_path_metric_select.sv
// Bench for path_metric_select: vector table plus random vectors against a value-first reference model.
module tb_path_metric_select;

  localparam int NP = 16;
  localparam int MW = 30;
  localparam logic [MW-1:0] MAXV = 30'h3FFFFFFF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            start4 = 1'b0;
  logic            flush = 1'b0;
  logic            sel_max = 1'b0;
  logic [NP*MW-1:0] metric_in = '0;
  logic            busy, done, busy4, done4;
  logic [3:0]      best_idx, best_idx4;
  logic [MW-1:0]   best_metric, best_metric4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  path_metric_select #(.NUM_PATH(NP), .MW(MW), .LANES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .sel_max(sel_max),
    .metric_in(metric_in), .busy(busy), .done(done),
    .best_idx(best_idx), .best_metric(best_metric));

  path_metric_select #(.NUM_PATH(NP), .MW(MW), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .flush(flush), .sel_max(sel_max),
    .metric_in(metric_in), .busy(busy4), .done(done4),
    .best_idx(best_idx4), .best_metric(best_metric4));

  typedef struct {
    logic [NP*MW-1:0] bus;
    logic             smax;
    logic [3:0]       eidx;
    logic [MW-1:0]    emet;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NP*MW-1:0] fill(input logic [MW-1:0] v);
    logic [NP*MW-1:0] r;
    for (int p = 0; p < NP; p++) r[p*MW +: MW] = v;
    return r;
  endfunction

  // Reference: find the extreme value first, then the lowest path holding it.
  task automatic ref_best(input logic [NP*MW-1:0] bus, input logic smax,
                          output logic [3:0] idx, output logic [MW-1:0] met);
    logic [MW-1:0] ext;
    ext = bus[0 +: MW];
    for (int p = 1; p < NP; p++) begin
      if (smax && bus[p*MW +: MW] > ext) ext = bus[p*MW +: MW];
      if (!smax && bus[p*MW +: MW] < ext) ext = bus[p*MW +: MW];
    end
    idx = '0;
    for (int p = NP - 1; p >= 0; p--) if (bus[p*MW +: MW] == ext) idx = 4'(p);
    met = ext;
  endtask

  // Drives start for one edge (the accepting edge); returns #1 after that edge.
  task automatic launch(input logic [NP*MW-1:0] bus, input logic smax, input bit u4);
    @(posedge clk); #1;
    metric_in = bus;
    sel_max   = smax;
    if (u4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if it never comes within the budget.
  task automatic wait_done(input bit u4, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      n++;
      if (u4 ? done4 : done) return;
    end
    n = -1;
  endtask

  initial begin
    vec_t v;
    logic [NP*MW-1:0] bus, t1, t2, t3, t0;
    logic [3:0] ridx;
    logic [MW-1:0] rmet;
    int n, n2;

    // Reset state
    #3;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_idx", 64'(best_idx), 64'(0));
    chk("rst_met", 64'(best_metric), 64'(0));
    chk("rst_idx4", 64'(best_idx4), 64'(0));
    @(negedge clk); rst = 1'b0;

    t1 = fill(MW'(100)); t1[5*MW +: MW] = MW'(3);
    t2 = fill(MW'(50));  t2[2*MW +: MW] = MW'(7); t2[9*MW +: MW] = MW'(7);
    for (int p = 0; p < NP; p++) t3[p*MW +: MW] = MW'($urandom_range(0, 32'h3FFFFFFE));
    t3[15*MW +: MW] = MAXV;
    t0 = fill(MW'(20)); t0[0 +: MW] = '0;

    tbl.push_back('{bus: t1, smax: 1'b0, eidx: 4'd5,  emet: MW'(3)});
    tbl.push_back('{bus: t2, smax: 1'b0, eidx: 4'd2,  emet: MW'(7)});
    tbl.push_back('{bus: t3, smax: 1'b1, eidx: 4'd15, emet: MAXV});
    for (int k = 0; k < 10; k++) begin
      for (int p = 0; p < NP; p++)
        bus[p*MW +: MW] = (k % 2 == 0) ? MW'($urandom_range(0, 7)) : MW'($urandom);
      v.bus  = bus;
      v.smax = 1'($urandom_range(0, 1));
      ref_best(v.bus, v.smax, ridx, rmet);
      v.eidx = ridx;
      v.emet = rmet;
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      launch(tbl[i].bus, tbl[i].smax, 1'b0);
      chk($sformatf("busy_after_start[%0d]", i), 64'(busy), 64'(1));
      wait_done(1'b0, 60, n);
      chk($sformatf("latency[%0d]", i), 64'(n), 64'(17));
      chk($sformatf("busy_at_done[%0d]", i), 64'(busy), 64'(0));
      chk($sformatf("idx[%0d]", i), 64'(best_idx), 64'(tbl[i].eidx));
      chk($sformatf("met[%0d]", i), 64'(best_metric), 64'(tbl[i].emet));
    end

    // start while busy is ignored
    launch(t1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1; metric_in = t0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(1'b0, 60, n2);
    chk("restart_latency", 64'(4 + n2), 64'(17));
    chk("restart_idx", 64'(best_idx), 64'(5));
    chk("restart_met", 64'(best_metric), 64'(3));

    // start in the done cycle is accepted
    metric_in = t0; sel_max = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_done_pulse", 64'(done), 64'(0));
    wait_done(1'b0, 60, n);
    chk("b2b_latency", 64'(n), 64'(17));
    chk("b2b_idx", 64'(best_idx), 64'(0));
    chk("b2b_met", 64'(best_metric), 64'(0));

    // flush mid-scan: no done, best_* keep previous values
    launch(t1, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    wait_done(1'b0, 30, n);
    chk("flush_no_done", 64'(n), 64'(-1));
    chk("flush_idx", 64'(best_idx), 64'(0));
    chk("flush_met", 64'(best_metric), 64'(0));

    // flush wins over a simultaneous start in IDLE
    #1; metric_in = t1; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'(0));

    // reset mid-scan clears outputs without a clock edge
    launch(t1, 1'b0, 1'b0);
    wait_done(1'b0, 60, n);
    chk("pre_rst_idx", 64'(best_idx), 64'(5));
    launch(t2, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_idx", 64'(best_idx), 64'(0));
    chk("arst_met", 64'(best_metric), 64'(0));
    @(negedge clk); rst = 1'b0;
    wait_done(1'b0, 30, n);
    chk("arst_no_done", 64'(n), 64'(-1));

    // four-lane build
    launch(t1, 1'b0, 1'b1);
    wait_done(1'b1, 30, n);
    chk("l4_latency", 64'(n), 64'(5));
    chk("l4_idx", 64'(best_idx4), 64'(5));
    chk("l4_met", 64'(best_metric4), 64'(3));
    launch(t2, 1'b0, 1'b1);
    wait_done(1'b1, 30, n);
    chk("l4_tie_idx", 64'(best_idx4), 64'(2));
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < NP; p++) bus[p*MW +: MW] = MW'($urandom_range(0, 5));
      v.smax = 1'($urandom_range(0, 1));
      ref_best(bus, v.smax, ridx, rmet);
      launch(bus, v.smax, 1'b1);
      wait_done(1'b1, 30, n);
      chk($sformatf("l4_rand_lat[%0d]", k), 64'(n), 64'(5));
      chk($sformatf("l4_rand_idx[%0d]", k), 64'(best_idx4), 64'(ridx));
      chk($sformatf("l4_rand_met[%0d]", k), 64'(best_metric4), 64'(rmet));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
